// File: rtl/dsram_like_bridge_pkg.sv
// Shared definitions for the SRAM-port to sram-like bus bridge:
// FSM state encodings and bus transfer-size codes.
package dsram_like_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dsram_like_bridge_wen2size.sv
// Maps the CPU byte-lane write enables to a bus transfer size and the low
// address bits of the first enabled lane. Reads and irregular masks use a full word.
module dsram_like_bridge_wen2size
  import dsram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  always_comb begin
    size    = SIZE_WORD;
    addr_lo = 2'b00;
    case (wen)
      4'b0011: begin size = SIZE_HALF; addr_lo = 2'b00; end
      4'b1100: begin size = SIZE_HALF; addr_lo = 2'b10; end
      4'b0001: begin size = SIZE_BYTE; addr_lo = 2'b00; end
      4'b0010: begin size = SIZE_BYTE; addr_lo = 2'b01; end
      4'b0100: begin size = SIZE_BYTE; addr_lo = 2'b10; end
      4'b1000: begin size = SIZE_BYTE; addr_lo = 2'b11; end
      default: begin size = SIZE_WORD; addr_lo = 2'b00; end
    endcase
  end

endmodule

// File: rtl/dsram_like_bridge.sv
// Bridges the CPU single-cycle data SRAM port onto the sram-like req/addr_ok/data_ok
// bus with one transaction outstanding; cpu_stall freezes the pipeline until completion.
module dsram_like_bridge
  import dsram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              cpu_hold,
  input  logic              flush,
  output logic              cpu_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_e            state, state_n;
  logic              flush_pend, flush_pend_n;
  logic              req_c, take_rdata, issue;
  logic              wr_c, wr_p1;
  logic [1:0]        size_c, addr_lo_c, size_p1;
  logic [ADDR_W-1:0] addr_c, addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              unused_addr_lo;

  dsram_like_bridge_wen2size u_wen2size (
    .wen     (data_sram_wen),
    .size    (size_c),
    .addr_lo (addr_lo_c)
  );

  assign addr_c         = {data_sram_addr[ADDR_W-1:2], addr_lo_c};
  assign wr_c           = |data_sram_wen;
  assign unused_addr_lo = ^data_sram_addr[1:0];

  // A flush seen while the request waits for addr_ok is remembered so the
  // accepted transaction is drained instead of delivered.
  always_comb begin
    state_n      = state;
    flush_pend_n = flush_pend;
    req_c        = 1'b0;
    take_rdata   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_c        = data_sram_en & ~flush;
        flush_pend_n = 1'b0;
        if (req_c && data_addr_ok) begin
          if (data_data_ok) begin
            state_n    = ST_DONE;
            take_rdata = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end else if (req_c) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (data_addr_ok) begin
          flush_pend_n = 1'b0;
          if (flush || flush_pend) begin
            state_n = data_data_ok ? ST_IDLE : ST_DROP;
          end else if (data_data_ok) begin
            state_n    = ST_DONE;
            take_rdata = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end else if (flush) begin
          flush_pend_n = 1'b1;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_n = data_data_ok ? ST_IDLE : ST_DROP;
        end else if (data_data_ok) begin
          state_n    = ST_DONE;
          take_rdata = 1'b1;
        end
      end
      ST_DROP: begin
        if (data_data_ok) state_n = ST_IDLE;
      end
      ST_DONE: begin
        if (flush || !cpu_hold) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign issue = (state == ST_IDLE) & req_c;

  // Bus outputs come straight from the CPU port on the issue cycle and from the
  // captured copy while the request is held, so a flush cannot disturb them.
  assign data_req   = req_c & resetn;
  assign data_wr    = (state == ST_REQ) ? wr_p1    : wr_c;
  assign data_size  = (state == ST_REQ) ? size_p1  : size_c;
  assign data_addr  = (state == ST_REQ) ? addr_p1  : addr_c;
  assign data_wdata = (state == ST_REQ) ? wdata_p1 : data_sram_wdata;
  assign cpu_stall  = resetn & ((data_sram_en & ~flush & (state != ST_DONE)) |
                                (state == ST_DROP));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= flush_pend_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= '0;
    end else if (take_rdata) begin
      data_sram_rdata <= data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      addr_p1  <= addr_c;
      size_p1  <= size_c;
      wr_p1    <= wr_c;
      wdata_p1 <= data_sram_wdata;
    end
  end

endmodule

// File: tb/tb_dsram_like_bridge.sv
// Directed bench for dsram_like_bridge: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_dsram_like_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata;
  logic        hold;
  logic        flush;
  logic        stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic        aok;
  logic        dok;
  logic [31:0] brdata;

  int total = 0;
  int bad   = 0;
  int hs    = 0;

  dsram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (sram_rdata),
    .cpu_hold        (hold),
    .flush           (flush),
    .cpu_stall       (stall),
    .data_req        (req),
    .data_wr         (wr),
    .data_size       (size),
    .data_addr       (baddr),
    .data_wdata      (bwdata),
    .data_addr_ok    (aok),
    .data_data_ok    (dok),
    .data_rdata      (brdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: request outstanding, in flight, abandoned, result ready.
  logic        m_busy, m_wait, m_kill, m_done;
  logic [31:0] m_res;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wen;
  logic        m_r, m_k;

  function automatic logic [3:0] map_wen(input logic [3:0] w);
    logic [1:0] sz;
    logic [1:0] lo;
    sz = 2'd2;
    lo = 2'd0;
    if ($countones(w) == 1) begin
      sz = 2'd0;
      for (int i = 0; i < 4; i++) if (w[i]) lo = 2'(i);
    end else if (w == 4'b0011) begin
      sz = 2'd1;
    end else if (w == 4'b1100) begin
      sz = 2'd1;
      lo = 2'd2;
    end
    return {sz, lo};
  endfunction

  function automatic logic exp_req();
    return resetn && !m_wait && !m_done && (m_busy || (en && !flush));
  endfunction

  function automatic logic exp_stall();
    return resetn && ((en && !flush && !m_done) || (m_wait && m_kill));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 1'b0; m_wait = 1'b0; m_kill = 1'b0; m_done = 1'b0; m_res = '0;
    end else begin
      m_r = exp_req();
      if (m_done) begin
        if (flush || !hold) m_done = 1'b0;
      end else if (m_r) begin
        if (!m_busy) begin
          t_addr = addr; t_wen = wen; t_wdata = wdata; m_k = 1'b0;
        end else begin
          m_k = m_kill | flush;
        end
        if (aok) begin
          m_busy = 1'b0;
          if (dok) begin
            m_kill = 1'b0;
            if (!m_k) begin m_done = 1'b1; m_res = brdata; end
          end else begin
            m_wait = 1'b1; m_kill = m_k;
          end
        end else begin
          m_busy = 1'b1; m_kill = m_k;
        end
      end else if (m_wait) begin
        if (dok) begin
          m_wait = 1'b0;
          if (!(m_kill || flush)) begin m_done = 1'b1; m_res = brdata; end
          m_kill = 1'b0;
        end else if (flush) begin
          m_kill = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] a;
    logic [3:0]  w;
    logic [3:0]  sl;
    chk("m_req", {31'd0, req}, {31'd0, exp_req()});
    chk("m_stall", {31'd0, stall}, {31'd0, exp_stall()});
    if (!resetn) chk("m_rdata_rst", sram_rdata, 32'd0);
    if (m_done) chk("m_rdata", sram_rdata, m_res);
    if (exp_req()) begin
      a  = m_busy ? t_addr : addr;
      w  = m_busy ? t_wen : wen;
      sl = map_wen(w);
      chk("m_addr", baddr, {a[31:2], sl[1:0]});
      chk("m_size", {30'd0, size}, {30'd0, sl[3:2]});
      chk("m_wr", {31'd0, wr}, {31'd0, |w});
      chk("m_wdata", bwdata, m_busy ? t_wdata : wdata);
    end
    if (resetn && req && aok) hs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic [3:0]  tw_wen  [5] = '{4'b1100, 4'b0101, 4'b0010, 4'b0011, 4'b1000};
  logic [31:0] tw_addr [5] = '{32'h4001, 32'h4003, 32'h4000, 32'h4002, 32'h4000};
  logic [31:0] tw_exp  [5] = '{32'h4002, 32'h4000, 32'h4001, 32'h4000, 32'h4003};
  logic [1:0]  tw_size [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0};

  initial begin
    resetn = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata = '0; hold = 1'b0;
    flush = 1'b0; aok = 1'b0; dok = 1'b0; brdata = '0;
    step();
    en = 1'b1; addr = 32'h1000;
    settle();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", sram_rdata, 32'd0);
    step();
    en = 1'b0;
    resetn = 1'b1;
    step();

    // 1: single-cycle read
    en = 1'b1; wen = 4'b0000; addr = 32'h1000; aok = 1'b1; dok = 1'b1; brdata = 32'hDEADBEEF;
    settle();
    chk("t1_req", {31'd0, req}, 32'd1);
    chk("t1_stall", {31'd0, stall}, 32'd1);
    chk("t1_addr", baddr, 32'h1000);
    chk("t1_size", {30'd0, size}, 32'd2);
    step();
    aok = 1'b0; dok = 1'b0;
    settle();
    chk("t1_done_stall", {31'd0, stall}, 32'd0);
    chk("t1_rdata", sram_rdata, 32'hDEADBEEF);
    step();
    en = 1'b0;
    step();

    // 2: store byte, addr_ok after three waiting cycles
    en = 1'b1; wen = 4'b0100; addr = 32'h2003; wdata = 32'h00AB0000;
    for (int i = 0; i < 4; i++) begin
      aok = (i == 3);
      settle();
      chk("t2_req", {31'd0, req}, 32'd1);
      chk("t2_addr", baddr, 32'h2002);
      chk("t2_size", {30'd0, size}, 32'd0);
      chk("t2_wr", {31'd0, wr}, 32'd1);
      chk("t2_wdata", bwdata, 32'h00AB0000);
      step();
    end
    aok = 1'b0; dok = 1'b1; brdata = 32'd0;
    settle();
    chk("t2_wait_stall", {31'd0, stall}, 32'd1);
    step();
    dok = 1'b0;
    settle();
    chk("t2_done_stall", {31'd0, stall}, 32'd0);
    step();
    en = 1'b0; wen = '0;
    step();

    // 3: slow read, then result held by cpu_hold
    en = 1'b1; addr = 32'h1004; aok = 1'b1;
    step();
    aok = 1'b0; brdata = 32'hCAFEF00D;
    for (int i = 1; i <= 5; i++) begin
      dok = (i == 5);
      settle();
      chk("t3_wait_stall", {31'd0, stall}, 32'd1);
      step();
    end
    dok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hold = (k < 2);
      settle();
      chk("t3_hold_req", {31'd0, req}, 32'd0);
      chk("t3_hold_stall", {31'd0, stall}, 32'd0);
      chk("t3_hold_rdata", sram_rdata, 32'hCAFEF00D);
      step();
    end
    hold = 1'b0; addr = 32'h1010; aok = 1'b1; dok = 1'b1; brdata = 32'h0BADF00D;
    settle();
    chk("t3_idle_req", {31'd0, req}, 32'd1);
    step();
    aok = 1'b0; dok = 1'b0;
    step();
    en = 1'b0;
    step();

    // 4: flush while waiting for data
    en = 1'b1; addr = 32'h1008; aok = 1'b1;
    step();
    aok = 1'b0; flush = 1'b1;
    settle();
    chk("t4_flush_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0; en = 1'b0;
    settle();
    chk("t4_drop_stall", {31'd0, stall}, 32'd1);
    step();
    dok = 1'b1; brdata = 32'h12345678;
    settle();
    chk("t4_drop_stall2", {31'd0, stall}, 32'd1);
    step();
    dok = 1'b0;
    settle();
    chk("t4_after_stall", {31'd0, stall}, 32'd0);
    chk("t4_rdata_kept", sram_rdata, 32'h0BADF00D);
    step();

    // 5: reset during WAIT
    en = 1'b1; addr = 32'h100C; aok = 1'b1;
    step();
    aok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t5_req", {31'd0, req}, 32'd0);
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_rdata", sram_rdata, 32'd0);
    en = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // 6: back-to-back store and load
    hs = 0;
    en = 1'b1; wen = 4'b1111; addr = 32'h3000; wdata = 32'h55AA55AA; aok = 1'b1;
    settle();
    chk("t6_sw_stall", {31'd0, stall}, 32'd1);
    step();
    aok = 1'b0; dok = 1'b1; brdata = 32'd0;
    step();
    dok = 1'b0;
    settle();
    chk("t6_sw_done", {31'd0, stall}, 32'd0);
    step();
    wen = 4'b0000; aok = 1'b1;
    settle();
    chk("t6_lw_req", {31'd0, req}, 32'd1);
    chk("t6_lw_stall", {31'd0, stall}, 32'd1);
    chk("t6_lw_wr", {31'd0, wr}, 32'd0);
    step();
    aok = 1'b0; dok = 1'b1; brdata = 32'h55AA55AA;
    step();
    dok = 1'b0;
    settle();
    chk("t6_lw_rdata", sram_rdata, 32'h55AA55AA);
    chk("t6_lw_done", {31'd0, stall}, 32'd0);
    step();
    en = 1'b0;
    settle();
    chk("t6_handshakes", 32'(hs), 32'd2);
    step();

    // 7: flush while the request is still unaccepted
    en = 1'b1; addr = 32'h5000;
    settle();
    chk("t7_req", {31'd0, req}, 32'd1);
    step();
    flush = 1'b1;
    settle();
    chk("t7_flush_req", {31'd0, req}, 32'd1);
    step();
    flush = 1'b0; en = 1'b0; addr = 32'hFFFFFFFF; aok = 1'b1;
    settle();
    chk("t7_held_addr", baddr, 32'h5000);
    chk("t7_held_req", {31'd0, req}, 32'd1);
    step();
    aok = 1'b0;
    settle();
    chk("t7_drop_stall", {31'd0, stall}, 32'd1);
    step();
    dok = 1'b1; brdata = 32'h11112222;
    step();
    dok = 1'b0;
    settle();
    chk("t7_after_stall", {31'd0, stall}, 32'd0);
    chk("t7_rdata_kept", sram_rdata, 32'h55AA55AA);
    step();

    // 8: write-enable to size/lane mapping
    for (int j = 0; j < 5; j++) begin
      en = 1'b1; wen = tw_wen[j]; addr = tw_addr[j]; wdata = 32'hBEEF0000 + j;
      aok = 1'b1; dok = 1'b1; brdata = 32'd0;
      settle();
      chk("t8_addr", baddr, tw_exp[j]);
      chk("t8_size", {30'd0, size}, {30'd0, tw_size[j]});
      step();
      aok = 1'b0; dok = 1'b0;
      step();
    end
    en = 1'b0; wen = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
